// File: rtl/io_serial_if.sv
// io_serial_if: device select, register select and strobes from io_control.
// master = bus controller side, slave = io_serial device side.
interface io_serial_if;
  logic sel_n;
  logic rs;
  logic to_devn;
  logic from_devn;

  modport master (
    output sel_n,
    output rs,
    output to_devn,
    output from_devn
  );

  modport slave (
    input sel_n,
    input rs,
    input to_devn,
    input from_devn
  );
endinterface

// File: rtl/io_serial.sv
// io_serial: byte UART on the device I/O bus, TX FIFO plus optional receiver.
// Define IO_SERIAL_RX_EN to compile in the receiver; otherwise RX reads as 0.
module io_serial #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  io_serial_if.slave bus,
  inout  wire  [7:0] io_bus,
  output logic       tx,
  input  logic       rx
);
  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0] BIT_END = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_st_t;

  logic wr_en, rd_en;
  logic push, pop;
  assign wr_en = !bus.sel_n && !bus.to_devn;
  assign rd_en = !bus.sel_n && !bus.from_devn;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;

  assign fifo_empty = count == '0;
  assign fifo_full  = count == CW'(TX_DEPTH);
  assign push       = wr_en && !bus.rs && !fifo_full;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= io_bus;

  // Pointers wrap naturally: TX_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  ser_st_t    tx_st, tx_st_n;
  logic [7:0] tx_cnt, tx_cnt_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic       tx_last, tx_n;

  assign tx_last = tx_cnt == BIT_END;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
      tx     <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_sh  <= tx_sh_n;
      tx_bit <= tx_bit_n;
      tx     <= tx_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + 8'd1;
    tx_sh_n  = tx_sh;
    tx_bit_n = tx_bit;
    pop      = 1'b0;
    unique case (tx_st)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_sh_n = fifo_mem[rd_ptr];
          tx_st_n = S_START;
        end
      end
      S_START:
        if (tx_last) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = S_DATA;
        end
      S_DATA:
        if (tx_last) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_st_n = S_STOP;
        end
      S_STOP:
        if (tx_last) begin
          tx_cnt_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            tx_sh_n = fifo_mem[rd_ptr];
            tx_st_n = S_START;
          end else begin
            tx_st_n = S_IDLE;
          end
        end
      default: tx_st_n = S_IDLE;
    endcase
    // Line level follows the state being entered, so tx is a clean flop.
    case (tx_st_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = tx_sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err;

`ifdef IO_SERIAL_RX_EN
  localparam logic [7:0] HALF_END = 8'(CLKS_PER_BIT / 2 - 1);

  logic       rx_s1, rx_s2, rx_prev;
  ser_st_t    rx_st, rx_st_n;
  logic [7:0] rx_cnt, rx_cnt_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic       rx_done, rx_bad;
  logic       rd_data, rd_seen, rd_clr, ctl_wr;

  assign rd_data = rd_en && !bus.rs;
  assign rd_clr  = rd_data && !rd_seen;
  assign ctl_wr  = wr_en && bus.rs;

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + 8'd1;
    rx_sh_n  = rx_sh;
    rx_bit_n = rx_bit;
    rx_done  = 1'b0;
    rx_bad   = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_st_n = S_START;
      end
      S_START:
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st_n = S_STOP;
        end
      S_STOP:
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_st_n  = S_IDLE;
          rx_done  = rx_s2;
          rx_bad   = !rx_s2;
        end
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_sh     <= '0;
      rx_bit    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rd_seen   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_sh   <= rx_sh_n;
      rx_bit  <= rx_bit_n;
      rd_seen <= rd_data;
      if (ctl_wr && io_bus[2]) overrun   <= 1'b0;
      if (ctl_wr && io_bus[4]) frame_err <= 1'b0;
      if (rd_clr) rx_valid <= 1'b0;
      // A byte landing on the same edge as a data read replaces it cleanly.
      if (rx_done) begin
        if (rx_valid && !rd_clr) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
        end
      end
      if (rx_bad) frame_err <= 1'b1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_data   = '0;
  assign rx_valid  = 1'b0;
  assign overrun   = 1'b0;
  assign frame_err = 1'b0;
`endif

  logic       tx_busy;
  logic [7:0] status, rd_val;

  assign tx_busy = (tx_st != S_IDLE) || !fifo_empty;
  assign status  = {3'b0, frame_err, tx_busy, overrun, fifo_full, rx_valid};
  assign rd_val  = bus.rs ? status : rx_data;
  assign io_bus  = (rd_en && !reset) ? rd_val : 8'hzz;

endmodule

// File: tb/tb_io_serial.sv
// tb_io_serial: randomized bench for io_serial against a frame-level model.
// Receiver scenarios are exercised when IO_SERIAL_RX_EN is defined.
module tb_io_serial;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  wire  [7:0] io_bus;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  bit cap_en = 1'b0;
  bit cap_q[$];
  bit exp_q[$];

  io_serial_if bus_if ();

  assign io_bus = drv_en ? drv : 8'hzz;

  io_serial #(
    .CLKS_PER_BIT(CPB),
    .TX_DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_if),
    .io_bus(io_bus),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (cap_en) cap_q.push_back(tx);
  end

  function automatic void push_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      bit v;
      if (i == 0) v = 1'b0;
      else if (i == 9) v = 1'b1;
      else v = b[i-1];
      repeat (CPB) exp_q.push_back(v);
    end
  endfunction

  function automatic int wave_diff();
    int d = 0;
    if (cap_q.size() != exp_q.size()) return -1;
    foreach (cap_q[i]) if (cap_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic r, input logic [7:0] d);
    @(negedge clk);
    bus_if.sel_n   = 1'b0;
    bus_if.rs      = r;
    bus_if.to_devn = 1'b0;
    drv            = d;
    drv_en         = 1'b1;
    @(negedge clk);
    bus_if.sel_n   = 1'b1;
    bus_if.to_devn = 1'b1;
    drv_en         = 1'b0;
  endtask

  task automatic bus_read(input logic r, output logic [7:0] d);
    @(negedge clk);
    bus_if.sel_n     = 1'b0;
    bus_if.rs        = r;
    bus_if.from_devn = 1'b0;
    #1 d = io_bus;
    @(negedge clk);
    bus_if.sel_n     = 1'b1;
    bus_if.from_devn = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) rx = 1'b0;
      else if (i == 9) rx = stop;
      else rx = b[i-1];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic test_reset();
    logic [7:0] s;
    cyc(3);
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx);
    else n_pass++;
    rst = 1'b0;
    cyc(2);
    n_total++;
    if (tx !== 1'b1) $display("FAIL idle_tx: got %b want 1", tx);
    else n_pass++;
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL reset_status: got %h want 00", s);
    else n_pass++;
    bus_read(1'b0, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL reset_data: got %h want 00", s);
    else n_pass++;
  endtask

  task automatic test_tx_frame();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      int d;
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      cap_q.delete();
      exp_q.delete();
      push_frame(b);
      exp_q.push_back(1'b1);
      bus_write(1'b0, b);
      cap_en = 1'b1;
      cyc(41);
      cap_en = 1'b0;
      n_total++;
      if (cap_q.size() == 0 || cap_q[0] !== 1'b0)
        $display("FAIL tx_latency: byte %h first sample not low", b);
      else n_pass++;
      d = wave_diff();
      n_total++;
      if (d !== 0)
        $display("FAIL tx_frame %h: got %0d diffs (size %0d) want 0 (size %0d)",
                 b, d, cap_q.size(), exp_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, s;
    int guard, d, n;
    x = 8'($urandom);
    cap_q.delete();
    exp_q.delete();
    push_frame(x);
    for (int i = 1; i <= 4; i++) push_frame(8'(i));
    repeat (8) exp_q.push_back(1'b1);
    n = exp_q.size();
    bus_write(1'b0, x);
    cap_en = 1'b1;
    bus_if.sel_n   = 1'b0;
    bus_if.rs      = 1'b0;
    bus_if.to_devn = 1'b0;
    drv_en         = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drv = 8'(i);
      @(negedge clk);
    end
    bus_if.sel_n   = 1'b1;
    bus_if.to_devn = 1'b1;
    drv_en         = 1'b0;
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h0A) $display("FAIL b2b_full_status: got %h want 0a", s);
    else n_pass++;
    guard = 0;
    while (cap_q.size() < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    cap_en = 1'b0;
    d = wave_diff();
    n_total++;
    if (d !== 0)
      $display("FAIL b2b_wave: got %0d diffs (size %0d) want 0 (size %0d)",
               d, cap_q.size(), n);
    else n_pass++;
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL b2b_done_status: got %h want 00", s);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b1, b2, s;
    int d;
    b1 = 8'($urandom) & 8'hFB;
    b2 = 8'($urandom);
    bus_write(1'b0, b1);
    bus_write(1'b0, b2);
    cyc(13);
    n_total++;
    if (tx !== 1'b0) $display("FAIL mid_tx_low: got %b want 0", tx);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if (tx !== 1'b1) $display("FAIL rst_tx_async: got %b want 1", tx);
    else n_pass++;
    cyc(2);
    rst = 1'b0;
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL rst_status: got %h want 00", s);
    else n_pass++;
    cap_q.delete();
    exp_q.delete();
    repeat (30) exp_q.push_back(1'b1);
    cap_en = 1'b1;
    cyc(30);
    cap_en = 1'b0;
    d = wave_diff();
    n_total++;
    if (d !== 0) $display("FAIL rst_fifo_empty: got %0d diffs want 0", d);
    else n_pass++;
  endtask

`ifdef IO_SERIAL_RX_EN
  task automatic test_rx();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b, s;
      b = (k == 0) ? 8'h3C : 8'($urandom);
      send_frame(b, 1'b1);
      bus_read(1'b1, s);
      n_total++;
      if (s !== 8'h01) $display("FAIL rx_status %h: got %h want 01", b, s);
      else n_pass++;
      bus_read(1'b0, s);
      n_total++;
      if (s !== b) $display("FAIL rx_data: got %h want %h", s, b);
      else n_pass++;
      bus_read(1'b1, s);
      n_total++;
      if (s !== 8'h00) $display("FAIL rx_cleared: got %h want 00", s);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic [7:0] a, b, s;
    a = 8'($urandom);
    b = ~a;
    send_frame(a, 1'b1);
    send_frame(b, 1'b1);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h05) $display("FAIL ovr_status: got %h want 05", s);
    else n_pass++;
    bus_write(1'b1, 8'h04);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h01) $display("FAIL ovr_clear: got %h want 01", s);
    else n_pass++;
    bus_read(1'b0, s);
    n_total++;
    if (s !== a) $display("FAIL ovr_data: got %h want %h", s, a);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [7:0] b, s;
    b = 8'($urandom);
    send_frame(b, 1'b0);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h10) $display("FAIL ferr_status: got %h want 10", s);
    else n_pass++;
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    cyc(3 * CPB);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h10) $display("FAIL glitch_status: got %h want 10", s);
    else n_pass++;
    bus_write(1'b1, 8'h10);
    send_frame(~b, 1'b1);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h01) $display("FAIL ferr_clear: got %h want 01", s);
    else n_pass++;
    bus_read(1'b0, s);
    n_total++;
    if (s !== ~b) $display("FAIL post_glitch_data: got %h want %h", s, ~b);
    else n_pass++;
  endtask
`else
  task automatic test_rx_disabled();
    logic [7:0] s;
    send_frame(8'h3C, 1'b1);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL norx_status: got %h want 00", s);
    else n_pass++;
    bus_read(1'b0, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL norx_data: got %h want 00", s);
    else n_pass++;
    send_frame(8'($urandom), 1'b0);
    bus_read(1'b1, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL norx_ferr: got %h want 00", s);
    else n_pass++;
  endtask
`endif

  initial begin
    bus_if.sel_n     = 1'b1;
    bus_if.rs        = 1'b0;
    bus_if.to_devn   = 1'b1;
    bus_if.from_devn = 1'b1;
    test_reset();
    test_tx_frame();
    test_back_to_back();
`ifdef IO_SERIAL_RX_EN
    test_rx();
    test_overrun();
    test_frame_err();
`else
    test_rx_disabled();
`endif
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
